rob_commit: RTL and testbench
=============================

# rob_commit

In-order retire stage at the read end of the ROB. Each cycle it examines up to COMMIT_WIDTH oldest entries, retires the ready prefix, and updates the committed architectural RAT (aRAT). It returns superseded physical registers to the free list. On a retired mispredicted branch it flushes the pipeline and streams the aRAT back to rename so the speculative RAT can be rebuilt.

## Interface
- ROB_SIZE, 8, ROB entries; ROB_IDX_W = $clog2(ROB_SIZE)
- NUM_ARCH_REGS, 32, architectural registers; areg 0 is hardwired zero
- NUM_PHYS_REGS, 64, physical registers; PREG_W = $clog2(NUM_PHYS_REGS)
- COMMIT_WIDTH, 4, max retirements per cycle; CNT_W = $clog2(COMMIT_WIDTH+1)

- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- commit_enable  in  1  external stall; 0 blocks all retirement
- head_valid[COMMIT_WIDTH]  in  1  slot i (head+i) occupied
- head_ready[COMMIT_WIDTH]  in  1  slot i completed
- head_has_dst[COMMIT_WIDTH]  in  1  slot i writes a register
- head_dst_areg[COMMIT_WIDTH]  in  5  destination arch reg
- head_dst_preg[COMMIT_WIDTH]  in  PREG_W  new physical reg
- head_old_preg[COMMIT_WIDTH]  in  PREG_W  previous mapping of dst_areg
- head_mispredict[COMMIT_WIDTH]  in  1  slot i is a mispredicted branch
- rob_deq_cnt  out  CNT_W  entries retired this cycle (ROB pops at the edge)
- free_valid[COMMIT_WIDTH]  out  1  free_preg[i] is released this cycle
- free_preg[COMMIT_WIDTH]  out  PREG_W  released physical reg
- flush_o  out  1  one-cycle pipeline flush pulse
- recover_valid  out  1  recovery beat valid
- recover_areg  out  5  arch reg being restored
- recover_preg  out  PREG_W  committed mapping for recover_areg
- recover_done  out  1  one-cycle pulse after the last beat
- retired_count  out  32  total retired instructions, wraps modulo 2^32

## Operation
- States: RUN and RECOVER.
- RUN: slot i retires iff commit_enable=1, head_valid[i]=1, head_ready[i]=1, and every slot j<i retires. Retirement is a strict prefix.
- A retiring slot with mispredict=1 terminates the prefix. That slot retires; younger slots do not.
- rob_deq_cnt = prefix length.
- A retiring slot with has_dst=1 and dst_areg≠0 does two things:
  - sets aRAT[dst_areg] ← dst_preg at the edge;
  - asserts free_valid[i] with free_preg[i] = old_preg.
- A slot with dst_areg=0 or has_dst=0 causes no aRAT write and no free.
- Multiple retiring slots writing the same areg in one cycle: the highest index (youngest) wins in the aRAT. Every old_preg is still freed.
- retired_count += rob_deq_cnt each cycle.
- A mispredict slot retiring moves the state to RECOVER at the edge.
- RECOVER:
  - rob_deq_cnt=0 and free_valid all 0; head inputs are ignored.
  - Counter r runs 0..NUM_ARCH_REGS-1. Each cycle drives recover_valid=1, recover_areg=r, recover_preg=aRAT[r].
  - After r=31, recover_done pulses and the state returns to RUN.
- Reset values:
  - state RUN; aRAT[i]=i; retired_count 0.
  - All outputs 0: flush_o, recover_*, rob_deq_cnt, free_valid.
- Reset mid-RECOVER aborts it. No recover_done is issued.

## Timing
- rob_deq_cnt, free_valid and free_preg are combinational from head_* and commit_enable in RUN (zero latency). The ROB consumer samples them at the same edge.
- aRAT updates are visible to recovery reads from the next cycle.
- flush_o is registered: it asserts in the first RECOVER cycle (cycle after the mispredict retires) and lasts exactly 1 cycle.
- Recovery beats: the first beat (areg 0) coincides with flush_o; the beats run for 32 consecutive cycles.
- recover_done is asserted in the cycle after the areg-31 beat, with the state already RUN. Retirement may resume in that same cycle.
- Minimum mispredict-to-resume: 33 cycles.
- commit_enable is ignored during RECOVER.

## Structure
- Package rob_pkg holds:
  - ROB_SIZE, NUM_ARCH_REGS, NUM_PHYS_REGS, COMMIT_WIDTH, PREG_W, CNT_W;
  - rob_commit_state_e {RUN, RECOVER};
  - packed struct rob_head_t grouping the per-slot head_* fields.
- Sub-module rob_arat: NUM_ARCH_REGS×PREG_W register file with COMMIT_WIDTH prioritised write ports (youngest wins), one async read port, and identity reset.
- rob_commit holds the prefix logic, free outputs, FSM, recovery counter and retired_count.

## Test plan
- Reset → rob_deq_cnt=0, flush_o=0, aRAT[5]=5; a recovery read returns preg 5 for areg 5.
- Slots 0–3 all valid and ready with areas 1,2,3,4 → preg 40..43 and old 1..4 → rob_deq_cnt=4; free 1,2,3,4; aRAT[1..4]=40..43; retired_count=4.
- Slot 1 not ready, slots 2–3 ready → rob_deq_cnt=1; only free_valid[0]=1.
- Slots 0 and 2 both write areg 7 → preg 50 and 51, old 7 and 50 → aRAT[7]=51; free 7 and 50.
- Slot 1 mispredict, slots 0–3 ready → rob_deq_cnt=2; next cycle flush_o=1 and recover areg 0; 32 beats; recover_done at beat +32.
- commit_enable=0 with all slots ready → rob_deq_cnt=0. Assert rst_n low at recovery beat 10 → no further beats, no recover_done, aRAT back to identity.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared parameters, FSM state type and per-slot head record for the ROB commit stage.
package rob_pkg;

  localparam int ROB_SIZE      = 8;
  localparam int ROB_IDX_W     = $clog2(ROB_SIZE);
  localparam int NUM_ARCH_REGS = 32;
  localparam int AREG_W        = $clog2(NUM_ARCH_REGS);
  localparam int NUM_PHYS_REGS = 64;
  localparam int PREG_W        = $clog2(NUM_PHYS_REGS);
  localparam int COMMIT_WIDTH  = 4;
  localparam int CNT_W         = $clog2(COMMIT_WIDTH + 1);

  typedef enum logic {
    RUN,
    RECOVER
  } rob_commit_state_e;

  // One of the COMMIT_WIDTH oldest ROB entries as seen by the retire stage.
  typedef struct packed {
    logic              valid;
    logic              ready;
    logic              has_dst;
    logic [AREG_W-1:0] dst_areg;
    logic [PREG_W-1:0] dst_preg;
    logic [PREG_W-1:0] old_preg;
    logic              mispredict;
  } rob_head_t;

endpackage

// File: rtl/rob_commit_if.sv
// Bundle between the ROB read end / rename / free list and the commit stage.
// The commit stage is the slave: it consumes the head window and produces
// retirement, free-list and recovery traffic.
interface rob_commit_if;
  import rob_pkg::*;

  logic                    commit_enable;
  rob_head_t               head [COMMIT_WIDTH];

  logic [CNT_W-1:0]        rob_deq_cnt;
  logic [COMMIT_WIDTH-1:0] free_valid;
  logic [PREG_W-1:0]       free_preg [COMMIT_WIDTH];
  logic                    flush_o;
  logic                    recover_valid;
  logic [AREG_W-1:0]       recover_areg;
  logic [PREG_W-1:0]       recover_preg;
  logic                    recover_done;
  logic [31:0]             retired_count;

  modport master (
    output commit_enable, head,
    input  rob_deq_cnt, free_valid, free_preg, flush_o,
           recover_valid, recover_areg, recover_preg, recover_done, retired_count
  );

  modport slave (
    input  commit_enable, head,
    output rob_deq_cnt, free_valid, free_preg, flush_o,
           recover_valid, recover_areg, recover_preg, recover_done, retired_count
  );

endinterface

// File: rtl/rob_arat.sv
// Committed architectural RAT: one entry per arch reg, several write ports
// applied oldest-to-youngest so the youngest writer of an areg wins, and one
// asynchronous read port used to stream mappings back during recovery.
module rob_arat
  import rob_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [COMMIT_WIDTH-1:0] wr_en,
  input  logic [AREG_W-1:0]       wr_areg [COMMIT_WIDTH],
  input  logic [PREG_W-1:0]       wr_preg [COMMIT_WIDTH],
  input  logic [AREG_W-1:0]       rd_areg,
  output logic [PREG_W-1:0]       rd_preg
);

  logic [PREG_W-1:0] regs [NUM_ARCH_REGS];

  // Identity mapping out of reset; later ports overwrite earlier ones on the same areg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < NUM_ARCH_REGS; a++) begin
        regs[a] <= PREG_W'(a);
      end
    end else begin
      for (int w = 0; w < COMMIT_WIDTH; w++) begin
        if (wr_en[w]) begin
          regs[wr_areg[w]] <= wr_preg[w];
        end
      end
    end
  end

  assign rd_preg = regs[rd_areg];

endmodule

// File: rtl/rob_commit.sv
// In-order retire stage: retires the ready prefix of the head window, frees
// superseded physical registers, updates the aRAT and, after a retired
// mispredict, flushes and streams the whole aRAT back to rename.
module rob_commit
  import rob_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  rob_commit_if.slave  bus
);

  rob_commit_state_e       state_q;
  rob_commit_state_e       state_d;
  logic [COMMIT_WIDTH-1:0] retire;
  logic [COMMIT_WIDTH-1:0] arat_we;
  logic                    prefix_blocked;
  logic                    mispredict_retire;
  logic [CNT_W-1:0]        deq_cnt;
  logic [AREG_W-1:0]       rec_cnt_q;
  logic                    last_beat;
  logic                    flush_q;
  logic                    done_q;
  logic [31:0]             retired_q;
  logic [AREG_W-1:0]       wr_areg [COMMIT_WIDTH];
  logic [PREG_W-1:0]       wr_preg [COMMIT_WIDTH];
  logic [PREG_W-1:0]       free_preg [COMMIT_WIDTH];
  logic [PREG_W-1:0]       rd_preg;

  // Retire the longest ready prefix; a retiring mispredict closes the prefix behind itself.
  always_comb begin
    retire            = '0;
    mispredict_retire = 1'b0;
    deq_cnt           = '0;
    prefix_blocked    = (state_q != RUN) || !bus.commit_enable;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (!prefix_blocked && bus.head[i].valid && bus.head[i].ready) begin
        retire[i] = 1'b1;
        deq_cnt   = deq_cnt + CNT_W'(1);
        if (bus.head[i].mispredict) begin
          mispredict_retire = 1'b1;
          prefix_blocked    = 1'b1;
        end
      end else begin
        prefix_blocked = 1'b1;
      end
    end
  end

  // Retiring register writers (areg 0 excluded) both update the aRAT and free their old mapping.
  always_comb begin
    arat_we = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      arat_we[i]   = retire[i] && bus.head[i].has_dst && (bus.head[i].dst_areg != '0);
      wr_areg[i]   = bus.head[i].dst_areg;
      wr_preg[i]   = bus.head[i].dst_preg;
      free_preg[i] = arat_we[i] ? bus.head[i].old_preg : '0;
    end
  end

  rob_arat u_arat (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (arat_we),
    .wr_areg (wr_areg),
    .wr_preg (wr_preg),
    .rd_areg (rec_cnt_q),
    .rd_preg (rd_preg)
  );

  assign last_beat = (state_q == RECOVER) && (rec_cnt_q == AREG_W'(NUM_ARCH_REGS - 1));

  // State register for the RUN/RECOVER machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Enter recovery on a retired mispredict, leave after the final aRAT beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (mispredict_retire) state_d = RECOVER;
      RECOVER: if (last_beat)         state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Recovery walks areg 0..31; it is held at zero whenever retirement is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_cnt_q <= '0;
    end else if (state_q == RECOVER) begin
      rec_cnt_q <= rec_cnt_q + AREG_W'(1);
    end else begin
      rec_cnt_q <= '0;
    end
  end

  // Single-cycle flush on recovery entry and single-cycle done on recovery exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      flush_q <= (state_q == RUN) && mispredict_retire;
      done_q  <= last_beat;
    end
  end

  // Running total of retired instructions, free to wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_q + 32'(deq_cnt);
    end
  end

  assign bus.rob_deq_cnt   = deq_cnt;
  assign bus.free_valid    = arat_we;
  assign bus.free_preg     = free_preg;
  assign bus.flush_o       = flush_q;
  assign bus.recover_valid = (state_q == RECOVER);
  assign bus.recover_areg  = (state_q == RECOVER) ? rec_cnt_q : '0;
  assign bus.recover_preg  = (state_q == RECOVER) ? rd_preg : '0;
  assign bus.recover_done  = done_q;
  assign bus.retired_count = retired_q;

endmodule

// File: tb/tb_rob_commit.sv
// Scoreboard bench for rob_commit: the driver computes each cycle's expected
// outputs from an architectural model and queues them; a monitor compares them
// mid-cycle against the DUT.
module tb_rob_commit;
  import rob_pkg::*;

  typedef struct packed {
    logic [CNT_W-1:0]                    deq;
    logic [COMMIT_WIDTH-1:0]             fv;
    logic [COMMIT_WIDTH-1:0][PREG_W-1:0] fp;
    logic                                flush;
    logic                                rvalid;
    logic [AREG_W-1:0]                   rareg;
    logic [PREG_W-1:0]                   rpreg;
    logic                                rdone;
    logic [31:0]                         count;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rob_commit_if bus ();

  rob_commit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t      exp_q [$];
  int        checks = 0;
  int        errors = 0;

  rob_head_t stim [COMMIT_WIDTH];
  logic      stim_ce;

  int          m_arat [NUM_ARCH_REGS];
  bit          m_recover;
  int          m_r;
  bit          m_flush;
  bit          m_done;
  logic [31:0] m_count;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < NUM_ARCH_REGS; a++) m_arat[a] = a;
    m_recover = 0;
    m_r       = 0;
    m_flush   = 0;
    m_done    = 0;
    m_count   = '0;
  endtask

  task automatic idle_stim();
    stim_ce = 1'b0;
    for (int i = 0; i < COMMIT_WIDTH; i++) stim[i] = '0;
  endtask

  task automatic set_slot(input int i, input bit v, input bit r, input bit hd, input int areg,
                          input int preg, input int old, input bit mis);
    stim[i].valid      = v;
    stim[i].ready      = r;
    stim[i].has_dst    = hd;
    stim[i].dst_areg   = AREG_W'(areg);
    stim[i].dst_preg   = PREG_W'(preg);
    stim[i].old_preg   = PREG_W'(old);
    stim[i].mispredict = mis;
  endtask

  task automatic random_stim(input bit allow_mis);
    stim_ce = ($urandom_range(0, 9) != 0);
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      set_slot(i, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0,
               $urandom_range(0, NUM_ARCH_REGS - 1), $urandom_range(0, NUM_PHYS_REGS - 1),
               $urandom_range(0, NUM_PHYS_REGS - 1), allow_mis && ($urandom_range(0, 24) == 0));
    end
  endtask

  // Drive one cycle, queue what the DUT must show during it, then advance the model over the edge.
  task automatic apply_stimulus(input bit do_reset);
    exp_t e;
    int   n;
    bit   mis;
    @(posedge clk);
    #1;
    if (do_reset) begin
      rst_n = 1'b0;
      model_reset();
      idle_stim();
    end else begin
      rst_n = 1'b1;
    end
    bus.commit_enable = stim_ce;
    for (int i = 0; i < COMMIT_WIDTH; i++) bus.head[i] = stim[i];

    e       = '0;
    n       = 0;
    mis     = 0;
    e.flush = m_flush;
    e.rdone = m_done;
    e.count = m_count;
    if (m_recover) begin
      e.rvalid = 1'b1;
      e.rareg  = AREG_W'(m_r);
      e.rpreg  = PREG_W'(m_arat[m_r]);
    end else begin
      while (stim_ce && n < COMMIT_WIDTH && stim[n].valid && stim[n].ready && !mis) begin
        if (stim[n].has_dst && stim[n].dst_areg != 0) begin
          e.fv[n] = 1'b1;
          e.fp[n] = stim[n].old_preg;
          m_arat[stim[n].dst_areg] = stim[n].dst_preg;
        end
        mis = stim[n].mispredict;
        n++;
      end
      e.deq = CNT_W'(n);
    end
    exp_q.push_back(e);

    m_count = m_count + 32'(n);
    m_done  = m_recover && (m_r == NUM_ARCH_REGS - 1);
    m_flush = mis;
    if (m_recover) begin
      m_r++;
      if (m_r == NUM_ARCH_REGS) m_recover = 0;
    end else if (mis) begin
      m_recover = 1;
      m_r       = 0;
    end
  endtask

  // Monitor: mid-cycle, compare the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("rob_deq_cnt", 32'(bus.rob_deq_cnt), 32'(e.deq));
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
          check_output($sformatf("free_valid%0d", i), 32'(bus.free_valid[i]), 32'(e.fv[i]));
          if (e.fv[i]) check_output($sformatf("free_preg%0d", i), 32'(bus.free_preg[i]), 32'(e.fp[i]));
        end
        check_output("flush_o", 32'(bus.flush_o), 32'(e.flush));
        check_output("recover_valid", 32'(bus.recover_valid), 32'(e.rvalid));
        if (e.rvalid) begin
          check_output("recover_areg", 32'(bus.recover_areg), 32'(e.rareg));
          check_output("recover_preg", 32'(bus.recover_preg), 32'(e.rpreg));
        end
        check_output("recover_done", 32'(bus.recover_done), 32'(e.rdone));
        check_output("retired_count", bus.retired_count, e.count);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    model_reset();
    idle_stim();
    bus.commit_enable = 1'b0;
    for (int i = 0; i < COMMIT_WIDTH; i++) bus.head[i] = '0;

    apply_stimulus(1);
    apply_stimulus(1);
    idle_stim();
    apply_stimulus(0);

    $display("[TB] full-width retire");
    stim_ce = 1'b1;
    for (int i = 0; i < COMMIT_WIDTH; i++) set_slot(i, 1, 1, 1, i + 1, 40 + i, i + 1, 0);
    apply_stimulus(0);

    $display("[TB] prefix stops at not-ready slot");
    set_slot(0, 1, 1, 1, 6, 44, 6, 0);
    set_slot(1, 1, 0, 1, 12, 45, 12, 0);
    set_slot(2, 1, 1, 1, 13, 46, 13, 0);
    set_slot(3, 1, 1, 1, 14, 47, 14, 0);
    apply_stimulus(0);

    $display("[TB] same areg written twice");
    set_slot(0, 1, 1, 1, 7, 50, 7, 0);
    set_slot(1, 1, 1, 1, 0, 52, 9, 0);
    set_slot(2, 1, 1, 1, 7, 51, 50, 0);
    set_slot(3, 0, 1, 1, 15, 53, 15, 0);
    apply_stimulus(0);

    $display("[TB] commit_enable low");
    stim_ce = 1'b0;
    for (int i = 0; i < COMMIT_WIDTH; i++) set_slot(i, 1, 1, 1, 16 + i, 30 + i, 16 + i, 0);
    apply_stimulus(0);

    $display("[TB] mispredict in slot 1 and full recovery");
    stim_ce = 1'b1;
    for (int i = 0; i < COMMIT_WIDTH; i++) set_slot(i, 1, 1, 1, 8 + i, 54 + i, 8 + i, i == 1);
    apply_stimulus(0);
    for (int c = 0; c < 36; c++) begin
      random_stim(0);
      apply_stimulus(0);
    end

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      random_stim(1);
      apply_stimulus(0);
    end
    for (int c = 0; c < 34; c++) begin
      random_stim(0);
      apply_stimulus(0);
    end

    $display("[TB] reset during recovery");
    stim_ce = 1'b1;
    for (int i = 0; i < COMMIT_WIDTH; i++) set_slot(i, 1, 1, 1, 20 + i, 60 + i, 20 + i, i == 2);
    apply_stimulus(0);
    for (int c = 0; c < 10; c++) begin
      random_stim(0);
      apply_stimulus(0);
    end
    apply_stimulus(1);
    idle_stim();
    for (int c = 0; c < 4; c++) apply_stimulus(0);

    $display("[TB] recovery after reset shows identity map");
    stim_ce = 1'b1;
    idle_stim();
    stim_ce = 1'b1;
    set_slot(0, 1, 1, 0, 0, 0, 0, 1);
    apply_stimulus(0);
    idle_stim();
    for (int c = 0; c < 35; c++) apply_stimulus(0);

    @(negedge clk);
    @(negedge clk);
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
